// File: rtl/mult_pkg.sv
// Constants and state encoding shared by the 5x5 array multiplier and its
// downstream accumulator.
package mult_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned PROD_W = 2 * OP_W;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } acc_state_e;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product stream in, frame result out; both sides use valid/ready.
interface mult_accumulator_if
    import mult_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  out_count;
    logic              overflow;

    // Producer of products and consumer of results.
    modport master (
        output in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, acc_out, out_count, overflow
    );

    modport slave (
        input  in_valid, product, in_last, out_ready,
        output in_ready, out_valid, acc_out, out_count, overflow
    );

endinterface

// File: rtl/mult_accumulator.sv
// Sums a frame of multiplier products and holds the result until taken.
// ACC_W and CNT_W must match the parameters of the connected interface.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned MAX_TERMS = 12,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    mult_accumulator_if.slave  bus
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = bus.in_valid && (state_q != StHold);
    // Extra top bit captures the carry out of the accumulator.
    assign sum     = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, bus.product};
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = ACC_W'(bus.product);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (bus.in_last || MAX_TERMS == 1) ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum[ACC_W];
                    if (bus.in_last || cnt_inc == CNT_W'(MAX_TERMS)) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q != StHold);
    assign bus.out_valid = (state_q == StHold);
    assign bus.acc_out   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Drives a 16-bit and a 12-bit accumulator with identical product streams and
// compares both against a frame-level sum model.
module tb_mult_accumulator;

    import mult_pkg::*;

    localparam int unsigned MaxTerms = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;
    logic [PROD_W-1:0] product = '0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Frame-level model: running sum and term count of the open frame.
    bit          m_hold = 1'b0;
    bit          m_in_frame = 1'b0;
    int unsigned m_sum = 0;
    int unsigned m_cnt = 0;

    always #5 clk = ~clk;

    mult_accumulator_if #(.ACC_W(16), .CNT_W(4)) bus_w16 ();
    mult_accumulator_if #(.ACC_W(12), .CNT_W(4)) bus_w12 ();

    assign bus_w16.in_valid  = in_valid;
    assign bus_w16.product   = product;
    assign bus_w16.in_last   = in_last;
    assign bus_w16.out_ready = out_ready;
    assign bus_w12.in_valid  = in_valid;
    assign bus_w12.product   = product;
    assign bus_w12.in_last   = in_last;
    assign bus_w12.out_ready = out_ready;

    mult_accumulator #(.ACC_W(16), .MAX_TERMS(MaxTerms), .CNT_W(4)) u_dut_w16 (
        .clk (clk),
        .rst (rst),
        .bus (bus_w16)
    );

    mult_accumulator #(.ACC_W(12), .MAX_TERMS(MaxTerms), .CNT_W(4)) u_dut_w12 (
        .clk (clk),
        .rst (rst),
        .bus (bus_w12)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PROD_W-1:0] mul5(input int unsigned a, input int unsigned b);
        return PROD_W'(a * b);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_hold = 1'b0;
            m_in_frame = 1'b0;
            m_sum = 0;
            m_cnt = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                m_sum = 0;
                m_cnt = 0;
            end
        end else if (in_valid) begin
            if (!m_in_frame) begin
                m_in_frame = 1'b1;
                m_sum = 0;
                m_cnt = 0;
            end
            m_sum += product;
            m_cnt++;
            if (in_last || m_cnt == MaxTerms) begin
                m_hold = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endtask

    // Results are checked only when idle or holding; mid-frame values are internal.
    task automatic check_outputs();
        check("w16_in_ready", bus_w16.in_ready, !m_hold);
        check("w16_out_valid", bus_w16.out_valid, m_hold);
        check("w12_in_ready", bus_w12.in_ready, !m_hold);
        check("w12_out_valid", bus_w12.out_valid, m_hold);
        if (!m_in_frame) begin
            check("w16_acc", bus_w16.acc_out, m_sum % 65536);
            check("w16_count", bus_w16.out_count, m_cnt);
            check("w16_ovf", bus_w16.overflow, m_sum >= 65536);
            check("w12_acc", bus_w12.acc_out, m_sum % 4096);
            check("w12_count", bus_w12.out_count, m_cnt);
            check("w12_ovf", bus_w12.overflow, m_sum >= 4096);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic beat(input int unsigned a, input int unsigned b, input logic last);
        in_valid = 1'b1;
        product = mul5(a, b);
        in_last = last;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic release_result();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset held with a beat presented; nothing may be counted.
        in_valid = 1'b1;
        product = mul5(3, 4);
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", bus_w16.in_ready, 1);
        check("rst_count", bus_w16.out_count, 0);

        beat(5, 5, 1'b0);
        beat(10, 10, 1'b0);
        beat(31, 31, 1'b1);
        check("t2_acc", bus_w16.acc_out, 1086);
        check("t2_count", bus_w16.out_count, 3);
        check("t2_valid", bus_w16.out_valid, 1);

        in_valid = 1'b1;
        product = mul5(2, 2);
        for (int i = 0; i < 5; i++) tick();
        check("t3_held_acc", bus_w16.acc_out, 1086);
        check("t3_held_ready", bus_w16.in_ready, 0);
        in_valid = 1'b0;
        release_result();
        check("t3_acc_clear", bus_w16.acc_out, 0);

        for (int i = 0; i < MaxTerms; i++) begin
            beat(31, 31, 1'b0);
            if (i % 3 == 1) tick();
        end
        check("t4_acc", bus_w16.acc_out, 11532);
        check("t4_count", bus_w16.out_count, 12);
        check("t4_ovf", bus_w16.overflow, 0);
        release_result();

        for (int i = 0; i < 5; i++) beat(31, 31, i == 4);
        check("t5_acc12", bus_w12.acc_out, 709);
        check("t5_ovf12", bus_w12.overflow, 1);
        check("t5_acc16", bus_w16.acc_out, 4805);
        release_result();
        beat(1, 3, 1'b1);
        check("t5_next_ovf12", bus_w12.overflow, 0);
        release_result();

        beat(5, 8, 1'b0);
        beat(5, 10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_acc", bus_w16.acc_out, 0);
        beat(1, 7, 1'b1);
        check("t6_acc", bus_w16.acc_out, 7);
        check("t6_count", bus_w16.out_count, 1);
        release_result();

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99) == 0);
            in_valid = ($urandom_range(3) != 0);
            product = mul5($urandom_range(31), $urandom_range(31));
            in_last = ($urandom_range(5) == 0);
            out_ready = $urandom_range(1);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
